// File: rtl/bip_control.sv
// Multi-cycle control unit for the accumulator datapath: fetch, load, decode and execute
// one 16-bit instruction every four cycles until HLT, with a saturating busy-cycle counter.
module bip_control #(
    parameter int NBITS       = 16,
    parameter int OPCODE_BITS = 5,
    parameter int ADDR_BITS   = 11
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NBITS-1:0]     i_instruction,
    output logic [ADDR_BITS-1:0] o_pc,
    output logic                 o_rd_prog,
    output logic [ADDR_BITS-1:0] o_operand,
    output logic                 o_rd_ram,
    output logic                 o_wr_ram,
    output logic [1:0]           o_sel_a,
    output logic                 o_sel_b,
    output logic                 o_op,
    output logic                 o_wr_acc,
    output logic                 o_busy,
    output logic                 o_halted,
    output logic                 o_illegal,
    output logic [NBITS-1:0]     o_cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_DECODE  = 3'd3,
        ST_EXECUTE = 3'd4,
        ST_HALTED  = 3'd5
    } state_t;

    localparam logic [OPCODE_BITS-1:0] OP_HLT  = 5'h00;
    localparam logic [OPCODE_BITS-1:0] OP_STO  = 5'h01;
    localparam logic [OPCODE_BITS-1:0] OP_LD   = 5'h02;
    localparam logic [OPCODE_BITS-1:0] OP_LDI  = 5'h03;
    localparam logic [OPCODE_BITS-1:0] OP_ADD  = 5'h04;
    localparam logic [OPCODE_BITS-1:0] OP_ADDI = 5'h05;
    localparam logic [OPCODE_BITS-1:0] OP_SUB  = 5'h06;
    localparam logic [OPCODE_BITS-1:0] OP_SUBI = 5'h07;

    localparam logic [1:0] SEL_A_RAM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    state_t                 state_r, state_s;
    logic [ADDR_BITS-1:0]   pc_r, pc_s;
    logic [NBITS-1:0]       ir_r, ir_s;
    logic [NBITS-1:0]       count_r, count_s, count_inc_s;
    logic [OPCODE_BITS-1:0] opcode_r, opcode_s;

    logic                   rd_prog_r, rd_prog_s;
    logic                   rd_ram_r, rd_ram_s;
    logic                   wr_ram_r, wr_ram_s;
    logic [1:0]             sel_a_r, sel_a_s;
    logic                   sel_b_r, sel_b_s;
    logic                   op_r, op_s;
    logic                   wr_acc_r, wr_acc_s;
    logic                   busy_r, busy_s;
    logic                   halted_r, halted_s;
    logic                   illegal_r, illegal_s;

    // Opcodes whose operand is a data-memory address that must be read ahead of EXECUTE.
    function automatic logic needs_ram(input logic [OPCODE_BITS-1:0] opc);
        return (opc == OP_LD) || (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

    assign opcode_r    = ir_r[NBITS-1 -: OPCODE_BITS];
    assign opcode_s    = ir_s[NBITS-1 -: OPCODE_BITS];
    assign count_inc_s = (count_r == {NBITS{1'b1}}) ? count_r
                                                    : count_r + {{(NBITS-1){1'b0}}, 1'b1};

    // Next-state, PC, IR and cycle-counter logic.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        ir_s    = ir_r;
        count_s = count_r;
        case (state_r)
            ST_IDLE, ST_HALTED: begin
                if (i_start) begin
                    state_s = ST_FETCH;
                    pc_s    = {ADDR_BITS{1'b0}};
                    count_s = {NBITS{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                state_s = ST_LOAD;
                count_s = count_inc_s;
            end
            ST_LOAD: begin
                state_s = ST_DECODE;
                ir_s    = i_instruction;
                count_s = count_inc_s;
            end
            ST_DECODE: begin
                state_s = ST_EXECUTE;
                count_s = count_inc_s;
            end
            ST_EXECUTE: begin
                pc_s    = pc_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                count_s = count_inc_s;
                if (opcode_r == OP_HLT) begin
                    state_s = ST_HALTED;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered strobes line up with it.
    always_comb begin
        rd_prog_s = 1'b0;
        rd_ram_s  = 1'b0;
        wr_ram_s  = 1'b0;
        sel_a_s   = SEL_A_RAM;
        sel_b_s   = 1'b0;
        op_s      = 1'b0;
        wr_acc_s  = 1'b0;
        busy_s    = 1'b0;
        halted_s  = 1'b0;
        illegal_s = 1'b0;
        case (state_s)
            ST_FETCH: begin
                busy_s    = 1'b1;
                rd_prog_s = 1'b1;
            end
            ST_LOAD: begin
                busy_s = 1'b1;
            end
            ST_DECODE: begin
                busy_s   = 1'b1;
                rd_ram_s = needs_ram(opcode_s);
            end
            ST_EXECUTE: begin
                busy_s = 1'b1;
                case (opcode_s)
                    OP_HLT:  wr_acc_s = 1'b0;
                    OP_STO:  wr_ram_s = 1'b1;
                    OP_LD:   wr_acc_s = 1'b1;
                    OP_LDI: begin
                        sel_a_s  = SEL_A_IMM;
                        wr_acc_s = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        sel_a_s  = SEL_A_ALU;
                        op_s     = (opcode_s == OP_SUB);
                        wr_acc_s = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        sel_a_s  = SEL_A_ALU;
                        sel_b_s  = 1'b1;
                        op_s     = (opcode_s == OP_SUBI);
                        wr_acc_s = 1'b1;
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            ST_HALTED: begin
                halted_s = 1'b1;
            end
            ST_IDLE: begin
                halted_s = 1'b0;
            end
            default: begin
                halted_s = 1'b0;
            end
        endcase
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= {ADDR_BITS{1'b0}};
            ir_r      <= {NBITS{1'b0}};
            count_r   <= {NBITS{1'b0}};
            rd_prog_r <= 1'b0;
            rd_ram_r  <= 1'b0;
            wr_ram_r  <= 1'b0;
            sel_a_r   <= 2'd0;
            sel_b_r   <= 1'b0;
            op_r      <= 1'b0;
            wr_acc_r  <= 1'b0;
            busy_r    <= 1'b0;
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            ir_r      <= ir_s;
            count_r   <= count_s;
            rd_prog_r <= rd_prog_s;
            rd_ram_r  <= rd_ram_s;
            wr_ram_r  <= wr_ram_s;
            sel_a_r   <= sel_a_s;
            sel_b_r   <= sel_b_s;
            op_r      <= op_s;
            wr_acc_r  <= wr_acc_s;
            busy_r    <= busy_s;
            halted_r  <= halted_s;
            illegal_r <= illegal_s;
        end
    end

    assign o_pc          = pc_r;
    assign o_rd_prog     = rd_prog_r;
    assign o_operand     = ir_r[ADDR_BITS-1:0];
    assign o_rd_ram      = rd_ram_r;
    assign o_wr_ram      = wr_ram_r;
    assign o_sel_a       = sel_a_r;
    assign o_sel_b       = sel_b_r;
    assign o_op          = op_r;
    assign o_wr_acc      = wr_acc_r;
    assign o_busy        = busy_r;
    assign o_halted      = halted_r;
    assign o_illegal     = illegal_r;
    assign o_cycle_count = count_r;

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: behavioural program/data memories and accumulator,
// expected per-cycle controls queued from each fetched instruction.
module tb_bip_control;

    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_DEC   = 2;
    localparam int K_EXEC  = 3;
    localparam int K_HALT  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        inject = 1'b1;
    logic [15:0] garbage = 16'hFFFF;
    logic [15:0] prog_q = 16'h0000;
    logic [15:0] instruction;
    logic [10:0] pc, operand;
    logic        rd_prog, rd_ram, wr_ram, sel_b, op, wr_acc, busy, halted, illegal;
    logic [1:0]  sel_a;
    logic [15:0] cycle_count;

    always #5 clk = ~clk;

    bip_control #(.NBITS(16), .OPCODE_BITS(5), .ADDR_BITS(11)) dut (
        .i_clock(clk), .i_reset(reset), .i_start(start), .i_instruction(instruction),
        .o_pc(pc), .o_rd_prog(rd_prog), .o_operand(operand), .o_rd_ram(rd_ram),
        .o_wr_ram(wr_ram), .o_sel_a(sel_a), .o_sel_b(sel_b), .o_op(op),
        .o_wr_acc(wr_acc), .o_busy(busy), .o_halted(halted), .o_illegal(illegal),
        .o_cycle_count(cycle_count)
    );

    // Behavioural program memory, data memory and accumulator datapath.
    logic [15:0] pmem [0:2047];
    logic [15:0] ram  [0:2047];
    logic [15:0] ram_q = 16'h0000;
    logic [15:0] acc = 16'h0000;
    logic [15:0] imm, opb, acc_next;
    int          wr_ram_pulses = 0;
    int          illegal_pulses = 0;

    assign instruction = inject ? garbage : prog_q;
    assign imm         = {{5{operand[10]}}, operand};
    assign opb         = sel_b ? imm : ram_q;
    assign acc_next    = (sel_a == 2'd0) ? ram_q : (sel_a == 2'd1) ? imm
                       : (op ? acc - opb : acc + opb);

    always @(posedge clk) begin
        if (rd_prog) prog_q <= pmem[pc];
        if (rd_ram) ram_q <= ram[operand];
        if (wr_ram) ram[operand] <= acc;
        if (wr_acc) acc <= acc_next;
        if (wr_ram) wr_ram_pulses <= wr_ram_pulses + 1;
        if (illegal) illegal_pulses <= illegal_pulses + 1;
    end

    typedef struct {
        int          cyc;
        int          kind;
        logic [8:0]  ctrl;
        logic [10:0] addr;
        int          cnt;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          halts = 0;
    int          checks = 0;
    int          errors = 0;
    bit          keep_start = 1'b0;
    logic [8:0]  dut_ctrl;

    assign dut_ctrl = {rd_prog, rd_ram, wr_ram, wr_acc, sel_a, sel_b, op, illegal};

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [8:0] mk(input bit rp, input bit rr, input bit wrr, input bit wa,
                                      input logic [1:0] sa, input bit sb_, input bit o, input bit il);
        return {rp, rr, wrr, wa, sa, sb_, o, il};
    endfunction

    function automatic logic [8:0] exec_ctrl(input logic [4:0] opc);
        case (opc)
            5'h00:   return mk(0, 0, 0, 0, 2'd0, 0, 0, 0);
            5'h01:   return mk(0, 0, 1, 0, 2'd0, 0, 0, 0);
            5'h02:   return mk(0, 0, 0, 1, 2'd0, 0, 0, 0);
            5'h03:   return mk(0, 0, 0, 1, 2'd1, 0, 0, 0);
            5'h04:   return mk(0, 0, 0, 1, 2'd2, 0, 0, 0);
            5'h05:   return mk(0, 0, 0, 1, 2'd2, 1, 0, 0);
            5'h06:   return mk(0, 0, 0, 1, 2'd2, 0, 1, 0);
            5'h07:   return mk(0, 0, 0, 1, 2'd2, 1, 1, 0);
            default: return mk(0, 0, 0, 0, 2'd0, 0, 0, 1);
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_FETCH: return "fetch";
            K_LOAD:  return "load";
            K_DEC:   return "decode";
            K_EXEC:  return "execute";
            default: return "halted";
        endcase
    endfunction

    // Pop every expectation due this cycle; a fetch expectation queues the next instruction's cycles.
    task automatic sb_step();
        exp_t        e;
        logic [15:0] ins;
        logic [4:0]  opc;
        logic        rdr;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check_value($sformatf("%s@%0d.ctrl", kname(e.kind), cyc), dut_ctrl, e.ctrl);
            check_value($sformatf("%s@%0d.busy", kname(e.kind), cyc), busy, (e.kind != K_HALT));
            check_value($sformatf("%s@%0d.halted", kname(e.kind), cyc), halted, (e.kind == K_HALT));
            if (e.kind == K_FETCH) begin
                check_value($sformatf("fetch@%0d.pc", cyc), pc, e.addr);
                check_value($sformatf("fetch@%0d.count", cyc), cycle_count, e.cnt);
                ins = pmem[e.addr];
                opc = ins[15:11];
                rdr = (opc == 5'h02) || (opc == 5'h04) || (opc == 5'h06);
                sb.push_back('{cyc + 1, K_LOAD, 9'h000, 11'd0, 0});
                sb.push_back('{cyc + 2, K_DEC, mk(0, rdr, 0, 0, 2'd0, 0, 0, 0), ins[10:0], 0});
                sb.push_back('{cyc + 3, K_EXEC, exec_ctrl(opc), ins[10:0], 0});
                if (opc == 5'h00) begin
                    sb.push_back('{cyc + 4, K_HALT, 9'h000, 11'd0, e.cnt + 4});
                    if (keep_start)
                        sb.push_back('{cyc + 5, K_FETCH, mk(1, 0, 0, 0, 2'd0, 0, 0, 0), 11'd0, 0});
                end else begin
                    sb.push_back('{cyc + 4, K_FETCH, mk(1, 0, 0, 0, 2'd0, 0, 0, 0),
                                   e.addr + 11'd1, e.cnt + 4});
                end
            end else if (e.kind == K_DEC || e.kind == K_EXEC) begin
                check_value($sformatf("%s@%0d.operand", kname(e.kind), cyc), operand, e.addr);
            end else if (e.kind == K_HALT) begin
                check_value($sformatf("halted@%0d.count", cyc), cycle_count, e.cnt);
                halts++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        sb_step();
    endtask

    task automatic start_run(input bit hold);
        sb.delete();
        start = 1'b1;
        cyc   = 0;
        sb.push_back('{1, K_FETCH, mk(1, 0, 0, 0, 2'd0, 0, 0, 0), 11'd0, 0});
        tick();
        if (!hold) start = 1'b0;
    endtask

    task automatic run_until(input int n_halts, input int budget);
        int k = 0;
        while (halts < n_halts && k < budget) begin
            tick();
            k++;
        end
        check_value("run_reaches_halt", halts, n_halts);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, ".pc"}, pc, 0);
        check_value({tag, ".ctrl"}, dut_ctrl, 0);
        check_value({tag, ".operand"}, operand, 0);
        check_value({tag, ".busy"}, busy, 0);
        check_value({tag, ".halted"}, halted, 0);
        check_value({tag, ".count"}, cycle_count, 0);
    endtask

    // Spot checks at fixed cycles of the LDI/ADDI/STO/SUB/HLT program.
    task automatic full_points();
        case (cyc)
            4:  begin check_value("c4.wr_acc", wr_acc, 1); check_value("c4.sel_a", sel_a, 1); end
            8:  begin
                check_value("c8.sel_a", sel_a, 2);
                check_value("c8.sel_b", sel_b, 1);
                check_value("c8.op", op, 0);
            end
            12: begin check_value("c12.wr_ram", wr_ram, 1); check_value("c12.operand", operand, 2); end
            13: check_value("c13.ram2", ram[2], 16'd8);
            15: begin check_value("c15.rd_ram", rd_ram, 1); check_value("c15.operand", operand, 2); end
            16: check_value("c16.op", op, 1);
            21: begin check_value("c21.halted", halted, 1); check_value("c21.count", cycle_count, 20); end
            default: ;
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w0, i0, k;
        logic [15:0] acc0;
        for (int i = 0; i < 2048; i++) pmem[i] = 16'h0000;

        // Reset with garbage on the instruction bus.
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) tick();
        check_all_zero("post_reset");
        inject = 1'b0;

        // Full program: LDI 5; ADDI 3; STO 2; SUB 2; HLT.
        pmem[0] = {5'h03, 11'd5};
        pmem[1] = {5'h05, 11'd3};
        pmem[2] = {5'h01, 11'd2};
        pmem[3] = {5'h06, 11'd2};
        pmem[4] = 16'h0000;
        start_run(1'b0);
        full_points();
        k = 0;
        while (halts < 1 && k < 40) begin
            tick();
            full_points();
            k++;
        end
        check_value("full.halts", halts, 1);
        check_value("full.acc", acc, 16'd0);
        repeat (3) tick();
        check_value("full.stays_halted", halted, 1);
        check_value("full.count_held", cycle_count, 20);

        // Undefined opcode 0x1F then HLT.
        pmem[0] = 16'hF800;
        pmem[1] = 16'h0000;
        i0 = illegal_pulses;
        w0 = wr_ram_pulses;
        start_run(1'b0);
        run_until(halts + 1, 40);
        check_value("undef.halt_cycle", cyc, 9);
        check_value("undef.illegal_pulses", illegal_pulses - i0, 1);
        check_value("undef.no_wr_ram", wr_ram_pulses - w0, 0);

        // Reset during DECODE of STO.
        pmem[0] = {5'h01, 11'd5};
        pmem[1] = 16'h0000;
        w0 = wr_ram_pulses;
        start_run(1'b0);
        tick();
        tick();
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        check_all_zero("midreset");
        repeat (4) tick();
        check_value("midreset.no_wr_ram", wr_ram_pulses - w0, 0);
        check_value("midreset.idle", busy, 0);
        start_run(1'b0);
        run_until(halts + 1, 40);
        check_value("midreset.rerun_wr_ram", wr_ram_pulses - w0, 1);

        // i_start held high through a run and into HALTED.
        pmem[0] = {5'h03, 11'd1};
        pmem[1] = {5'h05, 11'd2};
        pmem[2] = 16'h0000;
        keep_start = 1'b1;
        start_run(1'b1);
        run_until(halts + 1, 60);
        keep_start = 1'b0;
        tick();
        start = 1'b0;
        run_until(halts + 1, 60);
        repeat (3) tick();
        check_value("hold.stays_halted", halted, 1);
        check_value("hold.acc", acc, 16'd3);

        // PC wrap: illegal opcodes up to 2046, ADDI 1 at 2047, HLT at 0 on the second pass.
        for (int i = 0; i < 2047; i++) pmem[i] = 16'hF800;
        pmem[2047] = {5'h05, 11'd1};
        acc0 = acc;
        start_run(1'b0);
        repeat (12) tick();
        pmem[0] = 16'h0000;
        run_until(halts + 1, 9000);
        check_value("wrap.halt_cycle", cyc, 8197);
        check_value("wrap.acc", acc, acc0 + 16'd1);
        check_value("wrap.pc_after", pc, 11'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
